// File: rtl/echo_indication_arbiter.sv
// Round-robin arbiter sharing one echo indication port between N requester FIFOs.
// Optional per-channel saturating grant counters when ECHO_ARB_GRANT_CNT_EN is defined.
module echo_indication_arbiter #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int SW    = $clog2(N)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             arb_en,
    input  logic [N-1:0]     req__ENA,
    output logic [N-1:0]     req__RDY,
    input  logic [N*W-1:0]   req_v,
    input  logic             echo__RDY,
    output logic             echo__ENA,
    output logic [W-1:0]     echo_v,
    output logic [SW-1:0]    echo_src,
`ifdef ECHO_ARB_GRANT_CNT_EN
    output logic             busy,
    output logic [N*16-1:0]  grant_cnt
`else
    output logic             busy
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  full;
    logic [N-1:0]  empty;
    logic [N-1:0]  enq;
    logic [N-1:0]  deq;
    logic [W-1:0]  head [N];

    logic          out_valid_reg;
    logic [W-1:0]  echo_v_reg;
    logic [SW-1:0] echo_src_reg;
    logic [SW-1:0] last_grant_reg;

    logic          load_ok;
    logic          do_grant;
    logic          grant_found;
    logic [SW-1:0] grant_idx;
    logic [SW:0]   cand_sum;
    logic [SW-1:0] cand;

    // Per-channel FIFO; the extra pointer bit distinguishes full from empty.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            logic [W-1:0] mem [DEPTH];
            logic [AW:0]  wr_ptr_reg;
            logic [AW:0]  rd_ptr_reg;

            assign empty[gi]    = (wr_ptr_reg == rd_ptr_reg);
            assign full[gi]     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
            assign enq[gi]      = req__ENA[gi] & ~full[gi];
            assign deq[gi]      = do_grant && (grant_idx == SW'(gi));
            assign head[gi]     = mem[rd_ptr_reg[AW-1:0]];
            assign req__RDY[gi] = ~full[gi];

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (enq[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (deq[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end

            always_ff @(posedge CLK) begin
                if (enq[gi]) mem[wr_ptr_reg[AW-1:0]] <= req_v[gi*W +: W];
            end
        end
    endgenerate

    // Search last_grant+1, last_grant+2, ... modulo N; first non-empty wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            cand_sum = {1'b0, last_grant_reg} + (SW+1)'(k);
            cand     = (cand_sum >= (SW+1)'(N)) ? SW'(cand_sum - (SW+1)'(N)) : SW'(cand_sum);
            if (!grant_found && !empty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign echo__ENA = out_valid_reg & echo__RDY;
    assign load_ok   = arb_en & (~out_valid_reg | echo__ENA);
    assign do_grant  = load_ok & grant_found;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_reg  <= 1'b0;
            echo_v_reg     <= '0;
            echo_src_reg   <= '0;
            last_grant_reg <= SW'(N - 1);
        end else if (do_grant) begin
            out_valid_reg  <= 1'b1;
            echo_v_reg     <= head[grant_idx];
            echo_src_reg   <= grant_idx;
            last_grant_reg <= grant_idx;
        end else if (echo__ENA) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign echo_v   = echo_v_reg;
    assign echo_src = echo_src_reg;
    assign busy     = (~&empty) | out_valid_reg;

`ifdef ECHO_ARB_GRANT_CNT_EN
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cnt
            logic [15:0] cnt_reg;

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    cnt_reg <= '0;
                end else if (deq[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end

            assign grant_cnt[gi*16 +: 16] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_echo_indication_arbiter.sv
// Directed bench for echo_indication_arbiter: vector table plus hand-written corner sequences.
// Payload driven on channel i is {i[7:0], 16'h0, d}.
module tb_echo_indication_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           CLK;
    logic           nRST;
    logic           arb_en;
    logic [N-1:0]   req__ENA;
    logic [N-1:0]   req__RDY;
    logic [N*W-1:0] req_v;
    logic           echo__RDY;
    logic           echo__ENA;
    logic [W-1:0]   echo_v;
    logic [1:0]     echo_src;
    logic           busy;
`ifdef ECHO_ARB_GRANT_CNT_EN
    logic [N*16-1:0] grant_cnt;
`endif

    echo_indication_arbiter #(.N(N), .W(W), .DEPTH(2)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .arb_en    (arb_en),
        .req__ENA  (req__ENA),
        .req__RDY  (req__RDY),
        .req_v     (req_v),
        .echo__RDY (echo__RDY),
        .echo__ENA (echo__ENA),
        .echo_v    (echo_v),
        .echo_src  (echo_src),
`ifdef ECHO_ARB_GRANT_CNT_EN
        .busy      (busy),
        .grant_cnt (grant_cnt)
`else
        .busy      (busy)
`endif
    );

    typedef struct {
        logic        arb_en;
        logic [3:0]  ena;
        logic [7:0]  d;
        logic        exp_ena;
        logic [31:0] exp_v;
        logic [1:0]  exp_src;
        logic [3:0]  exp_rdy;
        logic        exp_busy;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int n_cmp  = 0;
    int n_fail = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t mk(input logic a, input logic [3:0] e, input logic [7:0] d,
                                input logic xe, input logic [31:0] xv, input logic [1:0] xs,
                                input logic [3:0] xr, input logic xb);
        vec_t r;
        r.arb_en   = a;
        r.ena      = e;
        r.d        = d;
        r.exp_ena  = xe;
        r.exp_v    = xv;
        r.exp_src  = xs;
        r.exp_rdy  = xr;
        r.exp_busy = xb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic [3:0] e, input logic [7:0] d, input logic r);
        arb_en    = a;
        req__ENA  = e;
        echo__RDY = r;
        for (int i = 0; i < N; i++) req_v[i*W +: W] = {8'(i), 16'h0, d};
    endtask

    // Drive on the falling edge, sample 1 ns later, well clear of the rising edge.
    task automatic cyc(input logic a, input logic [3:0] e, input logic [7:0] d, input logic r);
        @(negedge CLK);
        drive(a, e, d, r);
        #1;
    endtask

    initial begin
        int acc;

        nRST = 1'b0;
        drive(1'b1, 4'h0, 8'h00, 1'b1);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        #1;

        // Reset state
        chk("rst.rdy",  32'(req__RDY),  32'hF);
        chk("rst.ena",  32'(echo__ENA), 32'h0);
        chk("rst.busy", 32'(busy),      32'h0);
        chk("rst.v",    echo_v,         32'h0);
        chk("rst.src",  32'(echo_src),  32'h0);

        // Four channels preloaded with two entries each while arb_en=0, then released.
        vecs[0]  = mk(1'b0, 4'hF, 8'hA0, 1'b0, 32'h0,         2'd0, 4'hF,    1'b0);
        vecs[1]  = mk(1'b0, 4'hF, 8'hB0, 1'b0, 32'h0,         2'd0, 4'hF,    1'b1);
        vecs[2]  = mk(1'b1, 4'h0, 8'h00, 1'b0, 32'h0,         2'd0, 4'h0,    1'b1);
        vecs[3]  = mk(1'b1, 4'h0, 8'h00, 1'b1, 32'h0000_00A0, 2'd0, 4'b0001, 1'b1);
        vecs[4]  = mk(1'b1, 4'h0, 8'h00, 1'b1, 32'h0100_00A0, 2'd1, 4'b0011, 1'b1);
        vecs[5]  = mk(1'b1, 4'h0, 8'h00, 1'b1, 32'h0200_00A0, 2'd2, 4'b0111, 1'b1);
        vecs[6]  = mk(1'b1, 4'h0, 8'h00, 1'b1, 32'h0300_00A0, 2'd3, 4'hF,    1'b1);
        vecs[7]  = mk(1'b1, 4'h0, 8'h00, 1'b1, 32'h0000_00B0, 2'd0, 4'hF,    1'b1);
        vecs[8]  = mk(1'b1, 4'h0, 8'h00, 1'b1, 32'h0100_00B0, 2'd1, 4'hF,    1'b1);
        vecs[9]  = mk(1'b1, 4'h0, 8'h00, 1'b1, 32'h0200_00B0, 2'd2, 4'hF,    1'b1);
        vecs[10] = mk(1'b1, 4'h0, 8'h00, 1'b1, 32'h0300_00B0, 2'd3, 4'hF,    1'b1);
        vecs[11] = mk(1'b1, 4'h0, 8'h00, 1'b0, 32'h0,         2'd0, 4'hF,    1'b0);
        // Channel 2 alone streams three values back-to-back.
        vecs[12] = mk(1'b1, 4'b0100, 8'h11, 1'b0, 32'h0,         2'd0, 4'hF, 1'b0);
        vecs[13] = mk(1'b1, 4'b0100, 8'h22, 1'b0, 32'h0,         2'd0, 4'hF, 1'b1);
        vecs[14] = mk(1'b1, 4'b0100, 8'h33, 1'b1, 32'h0200_0011, 2'd2, 4'hF, 1'b1);
        vecs[15] = mk(1'b1, 4'h0,    8'h00, 1'b1, 32'h0200_0022, 2'd2, 4'hF, 1'b1);
        vecs[16] = mk(1'b1, 4'h0,    8'h00, 1'b1, 32'h0200_0033, 2'd2, 4'hF, 1'b1);
        vecs[17] = mk(1'b1, 4'h0,    8'h00, 1'b0, 32'h0,         2'd0, 4'hF, 1'b0);

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].arb_en, vecs[i].ena, vecs[i].d, 1'b1);
            $display("vec %0d: ena=%0b src=%0d v=0x%08h rdy=%04b busy=%0b",
                     i, echo__ENA, echo_src, echo_v, req__RDY, busy);
            chk($sformatf("vec%0d.ena", i),  32'(echo__ENA), 32'(vecs[i].exp_ena));
            chk($sformatf("vec%0d.rdy", i),  32'(req__RDY),  32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d.busy", i), 32'(busy),      32'(vecs[i].exp_busy));
            if (vecs[i].exp_ena) begin
                chk($sformatf("vec%0d.v", i),   echo_v,         vecs[i].exp_v);
                chk($sformatf("vec%0d.src", i), 32'(echo_src),  32'(vecs[i].exp_src));
            end
        end

        // Backpressure: ch0 pushes continuously with echo__RDY low.
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 4'b0001, 8'(8'hC1 + k), 1'b0);
            if (req__RDY[0]) acc++;
            $display("bp %0d: rdy0=%0b out_v=0x%08h", k, req__RDY[0], echo_v);
            if (k >= 2) begin
                chk($sformatf("bp%0d.hold_v", k), echo_v, 32'h0000_00C1);
                chk($sformatf("bp%0d.ena", k),    32'(echo__ENA), 32'h0);
            end
        end
        chk("bp.accepted", 32'(acc), 32'd3);
        chk("bp.rdy_full", 32'(req__RDY[0]), 32'h0);
        cyc(1'b1, 4'h0, 8'h00, 1'b1);
        chk("bp.first_ena", 32'(echo__ENA), 32'h1);
        chk("bp.first_v",   echo_v,         32'h0000_00C1);
        chk("bp.rdy_same",  32'(req__RDY[0]), 32'h0);
        cyc(1'b1, 4'h0, 8'h00, 1'b1);
        chk("bp.rdy_after", 32'(req__RDY[0]), 32'h1);
        chk("bp.second_v",  echo_v,         32'h0000_00C2);
        cyc(1'b1, 4'h0, 8'h00, 1'b1);
        chk("bp.third_v",   echo_v,         32'h0000_00C3);
        cyc(1'b1, 4'h0, 8'h00, 1'b1);
        chk("bp.idle_busy", 32'(busy),      32'h0);

        // arb_en low: loaded entry drains, queued entries stay put.
        cyc(1'b1, 4'b1010, 8'hD1, 1'b0);
        cyc(1'b1, 4'b0010, 8'hD2, 1'b0);
        cyc(1'b0, 4'h0, 8'h00, 1'b1);
        chk("en.drain_ena", 32'(echo__ENA), 32'h1);
        chk("en.drain_v",   echo_v,         32'h0100_00D1);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 4'h0, 8'h00, 1'b1);
            chk($sformatf("en.frozen%0d.ena", k),  32'(echo__ENA), 32'h0);
            chk($sformatf("en.frozen%0d.busy", k), 32'(busy),      32'h1);
        end
        cyc(1'b1, 4'h0, 8'h00, 1'b1);
        chk("en.resume_ena0", 32'(echo__ENA), 32'h0);
        cyc(1'b1, 4'h0, 8'h00, 1'b1);
        chk("en.resume_src", 32'(echo_src), 32'd3);
        chk("en.resume_v",   echo_v,        32'h0300_00D1);
        cyc(1'b1, 4'h0, 8'h00, 1'b1);
        chk("en.next_src",   32'(echo_src), 32'd1);
        chk("en.next_v",     echo_v,        32'h0100_00D2);
        cyc(1'b1, 4'h0, 8'h00, 1'b1);
        chk("en.idle_busy",  32'(busy),     32'h0);

        // Asynchronous reset mid-stream.
        cyc(1'b1, 4'hF, 8'hE0, 1'b0);
        cyc(1'b1, 4'h0, 8'h00, 1'b0);
        cyc(1'b1, 4'h0, 8'h00, 1'b1);
        chk("ar.pre_ena", 32'(echo__ENA), 32'h1);
        chk("ar.pre_src", 32'(echo_src),  32'd2);
        #2 nRST = 1'b0;
        #1;
        chk("ar.ena",  32'(echo__ENA), 32'h0);
        chk("ar.busy", 32'(busy),      32'h0);
        chk("ar.rdy",  32'(req__RDY),  32'hF);
        chk("ar.v",    echo_v,         32'h0);
        chk("ar.src",  32'(echo_src),  32'h0);
`ifdef ECHO_ARB_GRANT_CNT_EN
        chk("ar.grant_cnt_zero", 32'(grant_cnt != '0), 32'h0);
`endif
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, 4'b1001, 8'hF0, 1'b1);
        #1;
        chk("ar.rel_busy", 32'(busy), 32'h0);
        cyc(1'b1, 4'h0, 8'h00, 1'b1);
        chk("ar.wait_ena", 32'(echo__ENA), 32'h0);
        cyc(1'b1, 4'h0, 8'h00, 1'b1);
        chk("ar.first_src", 32'(echo_src), 32'd0);
        chk("ar.first_v",   echo_v,        32'h0000_00F0);
        cyc(1'b1, 4'h0, 8'h00, 1'b1);
        chk("ar.second_src", 32'(echo_src), 32'd3);
        chk("ar.second_v",   echo_v,        32'h0300_00F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
